minc_run_ctrl: RTL and testbench

Run-control sequencer for the minc accumulator core. It gates instruction execution with a per-cycle advance enable and accepts run, step, halt, breakpoint and core-reset commands over a valid/ready port. It also owns the program-ROM write port, so a host loader can stream a program in only while the core is halted. It sits between the host/debug interface and the core, which gains an advance-enable input; the core's PC value is fed back to this block.

---
 rtl/minc_pkg.sv | 27 ++
 rtl/minc_run_ctrl_if.sv | 36 +++
 rtl/minc_load_ctrl.sv | 51 +++++
 rtl/minc_run_ctrl.sv | 150 +++++++++++++++
 tb/tb_minc_run_ctrl.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/minc_pkg.sv
// Shared definitions for the minc core and its run-control sequencer:
// default bus widths, the run-state encoding and the host command codes.
package minc_pkg;

  localparam int DEF_PC_W   = 8;
  localparam int DEF_INSN_W = 10;
  localparam int DEF_CYC_W  = 16;

  typedef enum logic [1:0] {
    ST_HALTED = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_LOAD   = 2'd3
  } run_state_t;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_RUN        = 3'd1,
    OP_STEP       = 3'd2,
    OP_HALT       = 3'd3,
    OP_LOAD       = 3'd4,
    OP_SETBRK     = 3'd5,
    OP_CLRBRK     = 3'd6,
    OP_CORE_RESET = 3'd7
  } cmd_op_t;

endpackage

// File: rtl/minc_run_ctrl_if.sv
// Host-side bus of the run-control block: command port, program-loader
// word stream and the program-ROM write port it drives.
interface minc_run_ctrl_if
  import minc_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int INSN_W = DEF_INSN_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [PC_W-1:0]   cmd_arg;

  logic              ld_valid;
  logic              ld_ready;
  logic [INSN_W-1:0] ld_data;
  logic              ld_last;

  logic              rom_we;
  logic [PC_W-1:0]   rom_waddr;
  logic [INSN_W-1:0] rom_wdata;

  // Host / loader / ROM side
  modport master (
    output cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, ld_last,
    input  cmd_ready, ld_ready, rom_we, rom_waddr, rom_wdata
  );

  // Run-control block side
  modport slave (
    input  cmd_valid, cmd_op, cmd_arg, ld_valid, ld_data, ld_last,
    output cmd_ready, ld_ready, rom_we, rom_waddr, rom_wdata
  );

endinterface

// File: rtl/minc_load_ctrl.sv
// Program loader: accepts words while the sequencer is in LOAD, turns each
// handshake into a one-cycle ROM write at an auto-incrementing address, and
// flags the handshake that carries the last word.
module minc_load_ctrl
  import minc_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int INSN_W = DEF_INSN_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              active,
  input  logic              start,
  input  logic [PC_W-1:0]   start_addr,
  input  logic              ld_valid,
  input  logic [INSN_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              rom_we,
  output logic [PC_W-1:0]   rom_waddr,
  output logic [INSN_W-1:0] rom_wdata,
  output logic              done
);

  logic [PC_W-1:0] ptr;
  logic            fire;

  assign ld_ready = active;
  assign fire     = active & ld_valid;
  assign done     = fire & ld_last;

  // Register each accepted word as a write strobe; the pointer wraps naturally.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr       <= '0;
      rom_we    <= 1'b0;
      rom_waddr <= '0;
      rom_wdata <= '0;
    end else begin
      rom_we <= fire;
      if (start) begin
        ptr <= start_addr;
      end else if (fire) begin
        ptr       <= ptr + 1'b1;
        rom_waddr <= ptr;
        rom_wdata <= ld_data;
      end
    end
  end

endmodule

// File: rtl/minc_run_ctrl.sv
// Run-control sequencer for the minc accumulator core: decodes host commands,
// gates per-cycle execution, handles breakpoints, counts executed
// instructions and hands the ROM write port to the loader while halted.
module minc_run_ctrl
  import minc_pkg::*;
#(
  parameter int PC_W   = DEF_PC_W,
  parameter int INSN_W = DEF_INSN_W,
  parameter int CYC_W  = DEF_CYC_W
) (
  input  logic             CLK,
  input  logic             RESET,
  minc_run_ctrl_if.slave   bus,
  input  logic [PC_W-1:0]  pc_in,
  output logic             core_en,
  output logic             core_rst,
  output logic [1:0]       state,
  output logic             brk_hit,
  output logic [CYC_W-1:0] cyc_count
);

  run_state_t      cur_state;
  cmd_op_t         op;
  logic            brk_en;
  logic [PC_W-1:0] brk_addr;
  logic            first_run;
  logic            cmd_ready;
  logic            cmd_fire;
  logic            halt_req;
  logic            brk_match;
  logic            end_of_prog;
  logic            load_start;
  logic            load_done;

  assign op            = cmd_op_t'(bus.cmd_op);
  assign state         = cur_state;
  assign bus.cmd_ready = cmd_ready;

  // Execution gate and stop conditions, decoded from the current cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    cmd_ready   = 1'b0;
    core_en     = 1'b0;
    halt_req    = 1'b0;
    brk_match   = 1'b0;
    end_of_prog = 1'b0;
    load_start  = 1'b0;
    cmd_ready   = (cur_state == ST_HALTED) || (cur_state == ST_RUN);
    cmd_fire    = bus.cmd_valid && cmd_ready;
    if (cur_state == ST_RUN) begin
      halt_req  = cmd_fire && (op == OP_HALT);
      // The first RUN cycle ignores the match so a resume leaves the breakpoint.
      brk_match = brk_en && !first_run && (pc_in == brk_addr);
      core_en   = !halt_req && !brk_match;
      end_of_prog = core_en && (&pc_in);
    end else if (cur_state == ST_STEP) begin
      core_en = 1'b1;
    end else if (cur_state == ST_HALTED) begin
      load_start = cmd_fire && (op == OP_LOAD);
    end
  end

  minc_load_ctrl #(
    .PC_W   (PC_W),
    .INSN_W (INSN_W)
  ) u_load (
    .CLK        (CLK),
    .RESET      (RESET),
    .active     (cur_state == ST_LOAD),
    .start      (load_start),
    .start_addr (bus.cmd_arg),
    .ld_valid   (bus.ld_valid),
    .ld_data    (bus.ld_data),
    .ld_last    (bus.ld_last),
    .ld_ready   (bus.ld_ready),
    .rom_we     (bus.rom_we),
    .rom_waddr  (bus.rom_waddr),
    .rom_wdata  (bus.rom_wdata),
    .done       (load_done)
  );

  // Run-state FSM, breakpoint registers, core-reset pulse and instruction counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cur_state <= ST_HALTED;
      brk_en    <= 1'b0;
      brk_addr  <= '0;
      brk_hit   <= 1'b0;
      first_run <= 1'b0;
      core_rst  <= 1'b0;
      cyc_count <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      core_rst  <= 1'b0;
      first_run <= 1'b0;
      if (core_en && !(&cyc_count)) cyc_count <= cyc_count + 1'b1;

      case (cur_state)
        ST_HALTED: begin
          if (cmd_fire) begin
            case (op)
              OP_RUN: begin
                cur_state <= ST_RUN;
                first_run <= 1'b1;
                brk_hit   <= 1'b0;
              end
              OP_STEP: begin
                cur_state <= ST_STEP;
                brk_hit   <= 1'b0;
              end
              OP_LOAD: begin
                cur_state <= ST_LOAD;
                brk_hit   <= 1'b0;
              end
              OP_SETBRK: begin
                brk_addr <= bus.cmd_arg;
                brk_en   <= 1'b1;
              end
              OP_CLRBRK: brk_en <= 1'b0;
              OP_CORE_RESET: begin
                core_rst  <= 1'b1;
                cyc_count <= '0;
                brk_hit   <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_RUN: begin
          if (brk_match) begin
            brk_hit   <= 1'b1;
            cur_state <= ST_HALTED;
          end else if (halt_req || end_of_prog) begin
            cur_state <= ST_HALTED;
          end
        end
        ST_STEP: cur_state <= ST_HALTED;
        ST_LOAD: begin
          // Restart the core at PC 0 together with the final ROM write.
          if (load_done) begin
            cur_state <= ST_HALTED;
            core_rst  <= 1'b1;
          end
        end
        default: cur_state <= ST_HALTED;
      endcase
    end
  end

endmodule

// File: tb/tb_minc_run_ctrl.sv
// Directed bench for minc_run_ctrl with a minimal core model: the PC
// increments on core_en and clears on RESET or core_rst.
module tb_minc_run_ctrl;
  import minc_pkg::*;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  minc_run_ctrl_if bus();

  logic [7:0]  pc;
  logic        pc_set = 1'b0;
  logic [7:0]  pc_set_val = 8'h00;
  logic        core_en;
  logic        core_rst;
  logic [1:0]  state;
  logic        brk_hit;
  logic [15:0] cyc_count;

  int n_checks = 0;
  int n_fail   = 0;
  int en_total = 0;
  int rst_total = 0;
  int we_total = 0;

  minc_run_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .bus       (bus),
    .pc_in     (pc),
    .core_en   (core_en),
    .core_rst  (core_rst),
    .state     (state),
    .brk_hit   (brk_hit),
    .cyc_count (cyc_count)
  );

  // Core model
  always @(posedge CLK) begin
    if (pc_set)                pc <= pc_set_val;
    else if (RESET || core_rst) pc <= 8'h00;
    else if (core_en)          pc <= pc + 8'h01;
  end

  // Event counters
  always @(posedge CLK) begin
    if (core_en)    en_total  <= en_total + 1;
    if (core_rst)   rst_total <= rst_total + 1;
    if (bus.rom_we) we_total  <= we_total + 1;
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_arg   = arg;
    cycle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_arg   = 8'h00;
  endtask

  task automatic set_pc(input logic [7:0] v);
    pc_set     = 1'b1;
    pc_set_val = v;
    cycle();
    pc_set     = 1'b0;
  endtask

  task automatic wait_halted(input int max_cycles, input string name);
    int k;
    k = 0;
    while (state != 2'd0 && k < max_cycles) begin
      cycle();
      k++;
    end
    n_checks++;
    if (state != 2'd0) begin
      n_fail++;
      $display("FAIL %s_timeout: state=%0d after %0d cycles, want 0", name, state, max_cycles);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) cycle();
    RESET = 1'b0;
    repeat (5) cycle();
    n_checks++; if (state !== 2'd0)      begin n_fail++; $display("FAIL reset_state: got %0d want 0", state); end
    n_checks++; if (core_en !== 1'b0)    begin n_fail++; $display("FAIL reset_core_en: got %b want 0", core_en); end
    n_checks++; if (cyc_count !== 16'd0) begin n_fail++; $display("FAIL reset_cyc: got %0d want 0", cyc_count); end
    n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    n_checks++; if (bus.rom_we !== 1'b0) begin n_fail++; $display("FAIL reset_rom_we: got %b want 0", bus.rom_we); end
    n_checks++; if (brk_hit !== 1'b0)    begin n_fail++; $display("FAIL reset_brk_hit: got %b want 0", brk_hit); end
    n_checks++; if (core_rst !== 1'b0)   begin n_fail++; $display("FAIL reset_core_rst: got %b want 0", core_rst); end
  endtask

  task automatic test_step();
    int e0;
    set_pc(8'h03);
    e0 = en_total;
    send_cmd(OP_STEP, 8'h00);
    n_checks++; if (core_en !== 1'b1)    begin n_fail++; $display("FAIL step_core_en: got %b want 1", core_en); end
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL step_cmd_ready: got %b want 0", bus.cmd_ready); end
    repeat (3) cycle();
    n_checks++; if (en_total - e0 != 1)  begin n_fail++; $display("FAIL step_en_cycles: got %0d want 1", en_total - e0); end
    n_checks++; if (pc !== 8'h04)        begin n_fail++; $display("FAIL step_pc: got %h want 04", pc); end
    n_checks++; if (state !== 2'd0)      begin n_fail++; $display("FAIL step_state: got %0d want 0", state); end
    n_checks++; if (cyc_count !== 16'd1) begin n_fail++; $display("FAIL step_cyc: got %0d want 1", cyc_count); end
  endtask

  task automatic test_breakpoint();
    int e0;
    send_cmd(OP_SETBRK, 8'h05);
    set_pc(8'h00);
    e0 = en_total;
    send_cmd(OP_RUN, 8'h00);
    wait_halted(40, "brk_run");
    n_checks++; if (en_total - e0 != 5)  begin n_fail++; $display("FAIL brk_en_cycles: got %0d want 5", en_total - e0); end
    n_checks++; if (pc !== 8'h05)        begin n_fail++; $display("FAIL brk_pc: got %h want 05", pc); end
    n_checks++; if (brk_hit !== 1'b1)    begin n_fail++; $display("FAIL brk_hit: got %b want 1", brk_hit); end
    n_checks++; if (cyc_count !== 16'd6) begin n_fail++; $display("FAIL brk_cyc: got %0d want 6", cyc_count); end
    // Resume from the breakpoint, then halt after one executed instruction.
    e0 = en_total;
    send_cmd(OP_RUN, 8'h00);
    cycle();
    send_cmd(OP_HALT, 8'h00);
    cycle();
    n_checks++; if (en_total - e0 != 1)  begin n_fail++; $display("FAIL resume_en_cycles: got %0d want 1", en_total - e0); end
    n_checks++; if (pc !== 8'h06)        begin n_fail++; $display("FAIL resume_pc: got %h want 06", pc); end
    n_checks++; if (brk_hit !== 1'b0)    begin n_fail++; $display("FAIL resume_brk_hit: got %b want 0", brk_hit); end
    n_checks++; if (state !== 2'd0)      begin n_fail++; $display("FAIL resume_state: got %0d want 0", state); end
    n_checks++; if (cyc_count !== 16'd7) begin n_fail++; $display("FAIL resume_cyc: got %0d want 7", cyc_count); end
  endtask

  task automatic test_end_of_program();
    int e0;
    send_cmd(OP_CLRBRK, 8'h00);
    e0 = rst_total;
    send_cmd(OP_CORE_RESET, 8'h00);
    n_checks++; if (core_rst !== 1'b1)   begin n_fail++; $display("FAIL corerst_pulse: got %b want 1", core_rst); end
    cycle();
    n_checks++; if (core_rst !== 1'b0)   begin n_fail++; $display("FAIL corerst_width: got %b want 0", core_rst); end
    n_checks++; if (rst_total - e0 != 1) begin n_fail++; $display("FAIL corerst_count: got %0d want 1", rst_total - e0); end
    n_checks++; if (pc !== 8'h00)        begin n_fail++; $display("FAIL corerst_pc: got %h want 00", pc); end
    n_checks++; if (cyc_count !== 16'd0) begin n_fail++; $display("FAIL corerst_cyc: got %0d want 0", cyc_count); end
    for (int i = 0; i < 252; i++) begin
      send_cmd(OP_STEP, 8'h00);
      cycle();
    end
    n_checks++; if (pc !== 8'hFC)          begin n_fail++; $display("FAIL steps_pc: got %h want fc", pc); end
    n_checks++; if (cyc_count !== 16'd252) begin n_fail++; $display("FAIL steps_cyc: got %0d want 252", cyc_count); end
    e0 = en_total;
    send_cmd(OP_RUN, 8'h00);
    wait_halted(40, "eop_run");
    n_checks++; if (en_total - e0 != 4)    begin n_fail++; $display("FAIL eop_en_cycles: got %0d want 4", en_total - e0); end
    n_checks++; if (pc !== 8'h00)          begin n_fail++; $display("FAIL eop_pc: got %h want 00", pc); end
    n_checks++; if (cyc_count !== 16'd256) begin n_fail++; $display("FAIL eop_cyc: got %0d want 256", cyc_count); end
    n_checks++; if (brk_hit !== 1'b0)      begin n_fail++; $display("FAIL eop_brk_hit: got %b want 0", brk_hit); end
  endtask

  task automatic test_load();
    logic [9:0] words [3];
    logic [7:0] addrs [3];
    int r0;
    words[0] = 10'h101; words[1] = 10'h202; words[2] = 10'h3FF;
    addrs[0] = 8'hFE;   addrs[1] = 8'hFF;   addrs[2] = 8'h00;
    set_pc(8'h40);
    r0 = rst_total;
    send_cmd(OP_LOAD, 8'hFE);
    n_checks++; if (state !== 2'd3)         begin n_fail++; $display("FAIL load_state: got %0d want 3", state); end
    n_checks++; if (bus.ld_ready !== 1'b1)  begin n_fail++; $display("FAIL load_ld_ready: got %b want 1", bus.ld_ready); end
    n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL load_cmd_ready: got %b want 0", bus.cmd_ready); end
    for (int i = 0; i < 3; i++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = words[i];
      bus.ld_last  = (i == 2);
      cycle();
      n_checks++; if (bus.rom_we !== 1'b1)       begin n_fail++; $display("FAIL load_we[%0d]: got %b want 1", i, bus.rom_we); end
      n_checks++; if (bus.rom_waddr !== addrs[i]) begin n_fail++; $display("FAIL load_addr[%0d]: got %h want %h", i, bus.rom_waddr, addrs[i]); end
      n_checks++; if (bus.rom_wdata !== words[i]) begin n_fail++; $display("FAIL load_data[%0d]: got %h want %h", i, bus.rom_wdata, words[i]); end
      n_checks++; if (core_en !== 1'b0)          begin n_fail++; $display("FAIL load_core_en[%0d]: got %b want 0", i, core_en); end
    end
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
    n_checks++; if (core_rst !== 1'b1) begin n_fail++; $display("FAIL load_core_rst: got %b want 1", core_rst); end
    n_checks++; if (state !== 2'd0)    begin n_fail++; $display("FAIL load_done_state: got %0d want 0", state); end
    cycle();
    n_checks++; if (bus.rom_we !== 1'b0)  begin n_fail++; $display("FAIL load_we_after: got %b want 0", bus.rom_we); end
    n_checks++; if (rst_total - r0 != 1)  begin n_fail++; $display("FAIL load_rst_count: got %0d want 1", rst_total - r0); end
    n_checks++; if (pc !== 8'h00)         begin n_fail++; $display("FAIL load_pc: got %h want 00", pc); end
  endtask

  task automatic test_halt_and_brk();
    send_cmd(OP_SETBRK, 8'h10);
    set_pc(8'h0E);
    send_cmd(OP_RUN, 8'h00);
    cycle();
    cycle();
    n_checks++; if (pc !== 8'h10) begin n_fail++; $display("FAIL hb_pc_pre: got %h want 10", pc); end
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = OP_HALT;
    #1;
    n_checks++; if (core_en !== 1'b0) begin n_fail++; $display("FAIL hb_core_en: got %b want 0", core_en); end
    cycle();
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    n_checks++; if (state !== 2'd0)   begin n_fail++; $display("FAIL hb_state: got %0d want 0", state); end
    n_checks++; if (brk_hit !== 1'b1) begin n_fail++; $display("FAIL hb_brk_hit: got %b want 1", brk_hit); end
    n_checks++; if (pc !== 8'h10)     begin n_fail++; $display("FAIL hb_pc: got %h want 10", pc); end
    send_cmd(OP_CLRBRK, 8'h00);
  endtask

  task automatic test_reset_during_load();
    int w0;
    w0 = we_total;
    send_cmd(OP_LOAD, 8'h20);
    bus.ld_valid = 1'b1;
    bus.ld_data  = 10'h155;
    bus.ld_last  = 1'b0;
    cycle();
    n_checks++; if (bus.rom_we !== 1'b1)     begin n_fail++; $display("FAIL rl_we_first: got %b want 1", bus.rom_we); end
    n_checks++; if (bus.rom_waddr !== 8'h20) begin n_fail++; $display("FAIL rl_addr_first: got %h want 20", bus.rom_waddr); end
    bus.ld_data = 10'h0AA;
    RESET = 1'b1;
    cycle();
    n_checks++; if (bus.rom_we !== 1'b0) begin n_fail++; $display("FAIL rl_we_at_reset: got %b want 0", bus.rom_we); end
    n_checks++; if (state !== 2'd0)      begin n_fail++; $display("FAIL rl_state: got %0d want 0", state); end
    RESET = 1'b0;
    repeat (4) cycle();
    bus.ld_valid = 1'b0;
    n_checks++; if (we_total - w0 != 1)   begin n_fail++; $display("FAIL rl_we_count: got %0d want 1", we_total - w0); end
    n_checks++; if (bus.ld_ready !== 1'b0) begin n_fail++; $display("FAIL rl_ld_ready: got %b want 0", bus.ld_ready); end
    n_checks++; if (cyc_count !== 16'd0)  begin n_fail++; $display("FAIL rl_cyc: got %0d want 0", cyc_count); end
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 3'd0;
    bus.cmd_arg   = 8'h00;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = 10'h000;
    bus.ld_last   = 1'b0;
    test_reset();
    test_step();
    test_breakpoint();
    test_end_of_program();
    test_load();
    test_halt_and_brk();
    test_reset_during_load();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
